// File: rtl/cond_flag_unit.sv
// Purpose : NZCV status register, condition evaluation and write-back enable for the execute stage.
// Latency : cond_pass is combinational; flags, wb_en and the fail counter update one clock after acceptance.
// Backpres: stall freezes all state (except a counter clear); flush kills the instruction in execute.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   instr_valid, cond,    instruction in execute: valid, condition field,
//   s_bit, alu_flags      set-flags request and ALU {N,Z,C,V} result
//   stall, flush          pipeline control
//   psr_wr_en/_data       direct NZCV write, overrides an ALU update
//   clr_count             synchronous clear of cond_fail_count
//   flags, carry_out      registered NZCV and its C bit (ALU carry input)
//   cond_pass             condition outcome against the registered flags
//   wb_en                 registered write-back enable for the next stage
//   cond_fail_count       saturating count of accepted instructions that failed their condition
module cond_flag_unit #(
   parameter int          COUNT_W     = 16,
   parameter logic [3:0]  RESET_FLAGS = 4'b0000
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               instr_valid,
   input  logic [3:0]         cond,
   input  logic               s_bit,
   input  logic [3:0]         alu_flags,
   input  logic               stall,
   input  logic               flush,
   input  logic               psr_wr_en,
   input  logic [3:0]         psr_wr_data,
   input  logic               clr_count,
   output logic [3:0]         flags,
   output logic               carry_out,
   output logic               cond_pass,
   output logic               wb_en,
   output logic [COUNT_W-1:0] cond_fail_count
);

   logic [3:0]         flags_q, flags_d;
   logic               wb_en_q, wb_en_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic               flag_n, flag_z, flag_c, flag_v;
   logic               accepted;

   assign flag_n = flags_q[3];
   assign flag_z = flags_q[2];
   assign flag_c = flags_q[1];
   assign flag_v = flags_q[0];

   // Evaluated only against the registered flags; the ALU result of the
   // current instruction never feeds its own condition.
   always_comb begin
      cond_pass = 1'b0;
      case (cond)
         4'h0: cond_pass = flag_z;
         4'h1: cond_pass = !flag_z;
         4'h2: cond_pass = flag_c;
         4'h3: cond_pass = !flag_c;
         4'h4: cond_pass = flag_n;
         4'h5: cond_pass = !flag_n;
         4'h6: cond_pass = flag_v;
         4'h7: cond_pass = !flag_v;
         4'h8: cond_pass = flag_c && !flag_z;
         4'h9: cond_pass = !flag_c || flag_z;
         4'hA: cond_pass = (flag_n == flag_v);
         4'hB: cond_pass = (flag_n != flag_v);
         4'hC: cond_pass = !flag_z && (flag_n == flag_v);
         4'hD: cond_pass = flag_z || (flag_n != flag_v);
         4'hE: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   end

   assign accepted = instr_valid && !stall && !flush;

   always_comb begin
      flags_d = flags_q;
      wb_en_d = wb_en_q;
      count_d = count_q;

      if (!stall) begin
         // A direct write wins over a same-cycle ALU update.
         if (psr_wr_en) begin
            flags_d = psr_wr_data;
         end else if (accepted && cond_pass && s_bit) begin
            flags_d = alu_flags;
         end
         wb_en_d = accepted && cond_pass;
      end

      // Clear is honoured even while stalled.
      if (clr_count) begin
         count_d = '0;
      end else if (accepted && !cond_pass && (count_q != '1)) begin
         count_d = count_q + COUNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         flags_q <= RESET_FLAGS;
         wb_en_q <= 1'b0;
         count_q <= '0;
      end else begin
         flags_q <= flags_d;
         wb_en_q <= wb_en_d;
         count_q <= count_d;
      end
   end

   assign flags           = flags_q;
   assign carry_out       = flags_q[1];
   assign wb_en           = wb_en_q;
   assign cond_fail_count = count_q;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Purpose : directed-vector bench for cond_flag_unit (COUNT_W=4 to reach saturation quickly).
// Latency : inputs change 1ns after a rising edge; registered outputs are sampled 1ns after the next edge.
// Backpres: exercises stall, flush and their combination.
module tb_cond_flag_unit;

   localparam int CW = 4;

   logic          clk;
   logic          reset_n;
   logic          instr_valid;
   logic [3:0]    cond;
   logic          s_bit;
   logic [3:0]    alu_flags;
   logic          stall;
   logic          flush;
   logic          psr_wr_en;
   logic [3:0]    psr_wr_data;
   logic          clr_count;
   logic [3:0]    flags;
   logic          carry_out;
   logic          cond_pass;
   logic          wb_en;
   logic [CW-1:0] cond_fail_count;

   int checks = 0;
   int errors = 0;

   cond_flag_unit #(.COUNT_W(CW), .RESET_FLAGS(4'b0000)) dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .instr_valid     (instr_valid),
      .cond            (cond),
      .s_bit           (s_bit),
      .alu_flags       (alu_flags),
      .stall           (stall),
      .flush           (flush),
      .psr_wr_en       (psr_wr_en),
      .psr_wr_data     (psr_wr_data),
      .clr_count       (clr_count),
      .flags           (flags),
      .carry_out       (carry_out),
      .cond_pass       (cond_pass),
      .wb_en           (wb_en),
      .cond_fail_count (cond_fail_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      instr_valid = 1'b0; cond = 4'hE; s_bit = 1'b0; alu_flags = 4'h0;
      stall = 1'b0; flush = 1'b0; psr_wr_en = 1'b0; psr_wr_data = 4'h0;
      clr_count = 1'b0;
   endtask

   task automatic test_reset();
      idle();
      reset_n = 1'b1;
      @(posedge clk);
      #3;
      reset_n = 1'b0;   // mid-cycle, away from any edge
      #1;
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL reset_flags: got %b expected 0000", flags); end
      checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL reset_carry: got %b expected 0", carry_out); end
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL reset_wb_en: got %b expected 0", wb_en); end
      checks++; if (cond_fail_count !== 4'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", cond_fail_count); end
      #2;
      reset_n = 1'b1;
   endtask

   task automatic test_update_pair();
      idle();
      instr_valid = 1'b1; cond = 4'hE; s_bit = 1'b1; alu_flags = 4'b0100;
      #1;
      checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL al_pass: got %b expected 1", cond_pass); end
      tick();
      checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL upd_flags: got %b expected 0100", flags); end
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL upd_wb_en: got %b expected 1", wb_en); end
      cond = 4'h0;
      #1;
      checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL eq_after_upd: got %b expected 1", cond_pass); end
      cond = 4'h1; alu_flags = 4'b1000;
      #1;
      checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL ne_pass: got %b expected 0", cond_pass); end
      tick();
      checks++; if (flags !== 4'b0100) begin errors++; $display("FAIL noupd_flags: got %b expected 0100", flags); end
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL noupd_wb_en: got %b expected 0", wb_en); end
      checks++; if (cond_fail_count !== 4'd1) begin errors++; $display("FAIL noupd_count: got %0d expected 1", cond_fail_count); end
      idle();
   endtask

   task automatic test_signed();
      logic [15:0] exp_tab;
      idle();
      psr_wr_en = 1'b1; psr_wr_data = 4'b1001;
      tick();
      psr_wr_en = 1'b0;
      checks++; if (flags !== 4'b1001) begin errors++; $display("FAIL psr_1001: got %b expected 1001", flags); end
      // {LE,GT,LT,GE} at cond D,C,B,A for N=1,V=1
      cond = 4'hA; #1; checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL ge_1001: got %b expected 1", cond_pass); end
      cond = 4'hB; #1; checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL lt_1001: got %b expected 0", cond_pass); end
      cond = 4'hC; #1; checks++; if (cond_pass !== 1'b1) begin errors++; $display("FAIL gt_1001: got %b expected 1", cond_pass); end
      cond = 4'hD; #1; checks++; if (cond_pass !== 1'b0) begin errors++; $display("FAIL le_1001: got %b expected 0", cond_pass); end

      psr_wr_en = 1'b1; psr_wr_data = 4'b1000;
      tick();
      psr_wr_en = 1'b0;
      // N=1 Z=0 C=0 V=0, bit i = expected pass for cond i
      exp_tab = 16'b0110_1010_1001_1010;
      for (int i = 0; i < 16; i++) begin
         cond = 4'(i);
         #1;
         checks++;
         if (cond_pass !== exp_tab[i]) begin
            errors++; $display("FAIL cond_1000_%0h: got %b expected %b", i, cond_pass, exp_tab[i]);
         end
      end

      psr_wr_en = 1'b1; psr_wr_data = 4'b0110;
      tick();
      psr_wr_en = 1'b0;
      // N=0 Z=1 C=1 V=0
      exp_tab = 16'b0110_0110_1010_0101;
      for (int i = 0; i < 16; i++) begin
         cond = 4'(i);
         #1;
         checks++;
         if (cond_pass !== exp_tab[i]) begin
            errors++; $display("FAIL cond_0110_%0h: got %b expected %b", i, cond_pass, exp_tab[i]);
         end
      end
      idle();
   endtask

   task automatic test_psr_override();
      idle();
      instr_valid = 1'b1; cond = 4'hE; s_bit = 1'b1; alu_flags = 4'b1100;
      psr_wr_en = 1'b1; psr_wr_data = 4'b0010;
      tick();
      checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL psr_override_flags: got %b expected 0010", flags); end
      checks++; if (carry_out !== 1'b1) begin errors++; $display("FAIL psr_override_carry: got %b expected 1", carry_out); end
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL psr_override_wb_en: got %b expected 1", wb_en); end
      idle();
   endtask

   task automatic test_stall_flush();
      // Starting state: flags 0010, wb_en 1, count 1
      idle();
      stall = 1'b1; instr_valid = 1'b1; cond = 4'hE; s_bit = 1'b1; alu_flags = 4'b1111;
      psr_wr_en = 1'b1; psr_wr_data = 4'b0101;
      tick();
      checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL stall_flags: got %b expected 0010", flags); end
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL stall_wb_en: got %b expected 1", wb_en); end
      cond = 4'hF;
      tick();
      checks++; if (cond_fail_count !== 4'd1) begin errors++; $display("FAIL stall_count: got %0d expected 1", cond_fail_count); end
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL stall_wb_hold: got %b expected 1", wb_en); end

      idle();
      flush = 1'b1; instr_valid = 1'b1; cond = 4'hE; s_bit = 1'b1; alu_flags = 4'b1111;
      tick();
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL flush_wb_en: got %b expected 0", wb_en); end
      checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL flush_flags: got %b expected 0010", flags); end
      cond = 4'hF;
      tick();
      checks++; if (cond_fail_count !== 4'd1) begin errors++; $display("FAIL flush_count: got %0d expected 1", cond_fail_count); end

      // Back-to-back: accepted AL (no s_bit), then stall+flush together must hold wb_en
      idle();
      instr_valid = 1'b1; cond = 4'hE;
      tick();
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL b2b_wb_en: got %b expected 1", wb_en); end
      stall = 1'b1; flush = 1'b1;
      tick();
      checks++; if (wb_en !== 1'b1) begin errors++; $display("FAIL stall_flush_wb_en: got %b expected 1", wb_en); end
      idle();
   endtask

   task automatic test_saturation();
      int exp_cnt;
      idle();
      exp_cnt = 1;
      instr_valid = 1'b1; cond = 4'hF; s_bit = 1'b1; alu_flags = 4'b1111;
      for (int i = 0; i < 20; i++) begin
         tick();
         exp_cnt = (exp_cnt < 15) ? exp_cnt + 1 : 15;
         checks++;
         if (cond_fail_count !== 4'(exp_cnt)) begin
            errors++; $display("FAIL sat_count_%0d: got %0d expected %0d", i, cond_fail_count, exp_cnt);
         end
      end
      checks++; if (flags !== 4'b0010) begin errors++; $display("FAIL nv_flags: got %b expected 0010", flags); end
      // Clear wins over a simultaneous accepted failure
      clr_count = 1'b1;
      tick();
      checks++; if (cond_fail_count !== 4'd0) begin errors++; $display("FAIL clr_count: got %0d expected 0", cond_fail_count); end
      clr_count = 1'b0;
      tick();
      checks++; if (cond_fail_count !== 4'd1) begin errors++; $display("FAIL count_after_clr: got %0d expected 1", cond_fail_count); end
      // Clear also applies during stall
      stall = 1'b1; clr_count = 1'b1;
      tick();
      checks++; if (cond_fail_count !== 4'd0) begin errors++; $display("FAIL clr_in_stall: got %0d expected 0", cond_fail_count); end
      idle();
   endtask

   task automatic test_async_reset_stall();
      idle();
      psr_wr_en = 1'b1; psr_wr_data = 4'b1110;
      tick();
      psr_wr_en = 1'b0; instr_valid = 1'b1; cond = 4'hE;
      tick();
      cond = 4'hF;
      tick();
      checks++; if (cond_fail_count !== 4'd1) begin errors++; $display("FAIL pre_reset_count: got %0d expected 1", cond_fail_count); end
      stall = 1'b1; cond = 4'hE;
      tick();
      #2;
      reset_n = 1'b0;
      #1;
      checks++; if (flags !== 4'b0000) begin errors++; $display("FAIL stall_reset_flags: got %b expected 0000", flags); end
      checks++; if (carry_out !== 1'b0) begin errors++; $display("FAIL stall_reset_carry: got %b expected 0", carry_out); end
      checks++; if (cond_fail_count !== 4'd0) begin errors++; $display("FAIL stall_reset_count: got %0d expected 0", cond_fail_count); end
      #1;
      reset_n = 1'b1;
      idle();
      tick();
      checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL post_reset_wb_en: got %b expected 0", wb_en); end
   endtask

   initial begin
      test_reset();
      test_update_pair();
      test_signed();
      test_psr_override();
      test_stall_flush();
      test_saturation();
      test_async_reset_stall();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
